// File: rtl/saber_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : saber_mul_pkg
//  Description : Shared definitions for the negacyclic polynomial multiplier:
//                controller state type, operating-mode encodings and the
//                width of one result slot on the output bus.
//  Revision    : 1.0  initial release
// ============================================================================
package saber_mul_pkg;

    // Controller states, visited in declaration order for one operation.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_S = 3'd1,
        ST_MAC    = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Operating modes. The unused code 2'b11 behaves like c_MODE_CLR.
    localparam logic [1:0] c_MODE_CLR = 2'b00;  // clear, then multiply
    localparam logic [1:0] c_MODE_ACC = 2'b01;  // add product to accumulators
    localparam logic [1:0] c_MODE_SUB = 2'b10;  // subtract product

    // Each result coefficient occupies one 16-bit slot of the result bus.
    localparam int c_SLOT_W = 16;

endpackage : saber_mul_pkg
`default_nettype wire

// File: rtl/poly_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : poly_mac_unit
//  Description : One result coefficient: multiplies the broadcast public
//                coefficient by a small signed secret coefficient and adds
//                or subtracts the product into a QW-bit accumulator
//                (everything mod 2^QW).
//  Ports       : clk, rst (async, active low)
//                i_clr  - zero the accumulator (wins over i_en)
//                i_en   - perform one multiply-accumulate step
//                i_sub  - subtract instead of add
//                i_a    - public coefficient (unsigned, QW bits)
//                i_r    - secret coefficient (two's complement, SW+1 bits)
//                o_acc  - accumulator value
//  Revision    : 1.0  initial release
// ============================================================================
module poly_mac_unit
    import saber_mul_pkg::*;
#(
    parameter int QW = 13,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_sub,
    input  logic [QW-1:0] i_a,
    input  logic [SW:0]   i_r,
    output logic [QW-1:0] o_acc
);

    logic [QW-1:0] w_r_ext;
    logic [QW-1:0] w_prod;
    logic [QW-1:0] w_sum;
    logic [QW-1:0] r_acc;

    // Sign-extending the secret to QW bits lets a plain truncated product
    // give the correct signed result modulo 2^QW.
    assign w_r_ext = {{(QW-SW-1){i_r[SW]}}, i_r};
    assign w_prod  = i_a * w_r_ext;
    assign w_sum   = i_sub ? (r_acc - w_prod) : (r_acc + w_prod);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

    assign o_acc = r_acc;

endmodule : poly_mac_unit
`default_nettype wire

// File: rtl/poly_mul_param.sv
`default_nettype none
// ============================================================================
//  Module      : poly_mul_param
//  Description : Negacyclic polynomial multiplier (x^N = -1) of a public
//                polynomial (QW-bit coefficients) by a small signed secret
//                polynomial (SW-bit coefficients), with N parallel
//                accumulators supporting clear, accumulate and subtract.
//  Ports       : clk, rst       - clock, async active-low reset
//                start, mode    - launch an operation / select its mode
//                s_addr, s_data - secret ROM (one-cycle read latency)
//                a_addr, a_coeff- public coefficient source (one-cycle)
//                res_data, res_valid, res_ready - result beat handshake
//                busy, done     - status, one-cycle completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module poly_mul_param
    import saber_mul_pkg::*;
#(
    parameter int N     = 256,
    parameter int QW    = 13,
    parameter int SW    = 4,
    parameter int BUS_W = 64,
    parameter int LANES = BUS_W / 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    output logic [(((N*SW/BUS_W) > 1) ? $clog2(N*SW/BUS_W) : 1)-1:0] s_addr,
    input  logic [BUS_W-1:0]     s_data,
    output logic [$clog2(N)-1:0] a_addr,
    input  logic [QW-1:0]        a_coeff,
    output logic [BUS_W-1:0]     res_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int W_S   = N * SW / BUS_W;          // secret ROM words
    localparam int CPW   = BUS_W / SW;              // secret coeffs per word
    localparam int BEATS = N / LANES;               // result beats
    localparam int SAW   = (W_S > 1) ? $clog2(W_S) : 1;
    localparam int AW    = $clog2(N);
    localparam int CW    = $clog2(N + 1);           // counts up to N

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic [1:0]              r_mode;
    logic                    w_clr;
    logic                    w_ld_en;
    logic                    w_mac_en;
    logic                    w_sub;

    logic [N-1:0][SW:0]      r_rot;
    logic [N-1:0][SW:0]      w_rot_ld;
    logic [CPW-1:0][SW:0]    w_ld_word;
    logic [SW:0]             w_wrap;
    logic [N-1:0][QW-1:0]    w_acc;
    logic [AW-1:0]           w_base;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD_S;
                    w_clr       = (mode != c_MODE_ACC) && (mode != c_MODE_SUB);
                end
            end
            // One extra cycle beyond the address sweep absorbs the ROM latency.
            ST_LOAD_S: begin
                if (r_cnt == CW'(W_S)) begin
                    w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                if (r_cnt == CW'(N)) begin
                    w_state_nxt = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (res_ready && (r_cnt == CW'(BEATS - 1))) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shared phase counter: address in LOAD_S/MAC, beat index in UNLOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == ST_LOAD_S) || (r_state == ST_MAC) ||
                     ((r_state == ST_UNLOAD) && res_ready)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= c_MODE_CLR;
        end else if ((r_state == ST_IDLE) && start) begin
            r_mode <= mode;
        end
    end

    // Data returned in cycle k belongs to the address issued in cycle k-1.
    assign w_ld_en  = (r_state == ST_LOAD_S) && (r_cnt != '0);
    assign w_mac_en = (r_state == ST_MAC)    && (r_cnt != '0);
    assign w_sub    = (r_mode == c_MODE_SUB);

    assign s_addr    = (r_state == ST_LOAD_S) ? SAW'(r_cnt) : '0;
    assign a_addr    = (r_state == ST_MAC)    ? AW'(r_cnt)  : '0;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign res_valid = (r_state == ST_UNLOAD);

    // ------------------------------------------------------------------
    // Secret rotation register
    // ------------------------------------------------------------------
    always_comb begin
        w_ld_word = '0;
        for (int c = 0; c < CPW; c++) begin
            w_ld_word[c] = {s_data[SW*c + SW - 1], s_data[SW*c +: SW]};
        end
    end

    // Words enter at the top and shift down, so after W_S loads word 0
    // sits at coefficients 0..CPW-1.
    generate
        if (W_S == 1) begin : g_ld_single
            assign w_rot_ld = w_ld_word;
        end else begin : g_ld_shift
            assign w_rot_ld = {w_ld_word, r_rot[N-1:CPW]};
        end
    endgenerate

    // Multiplying by x: the coefficient leaving the top re-enters negated.
    // SW+1 bits keep the negation of the most negative secret exact.
    assign w_wrap = '0 - r_rot[N-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rot <= '0;
        end else if (w_ld_en) begin
            r_rot <= w_rot_ld;
        end else if (w_mac_en) begin
            r_rot <= {r_rot[N-2:0], w_wrap};
        end
    end

    // ------------------------------------------------------------------
    // Accumulator array
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < N; g++) begin : g_cell
            poly_mac_unit #(
                .QW (QW),
                .SW (SW)
            ) u_mac (
                .clk   (clk),
                .rst   (rst),
                .i_clr (w_clr),
                .i_en  (w_mac_en),
                .i_sub (w_sub),
                .i_a   (a_coeff),
                .i_r   (r_rot[g]),
                .o_acc (w_acc[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result beats: accumulators are frozen during UNLOAD, so the selected
    // beat is stable for as long as the consumer stalls.
    // ------------------------------------------------------------------
    assign w_base = AW'(r_cnt * LANES);

    always_comb begin
        res_data = '0;
        if (r_state == ST_UNLOAD) begin
            for (int l = 0; l < LANES; l++) begin
                res_data[c_SLOT_W*l +: QW] = w_acc[w_base + AW'(l)];
            end
        end
    end

endmodule : poly_mul_param
`default_nettype wire

// File: tb/tb_poly_mul_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_poly_mul_param
//  Description : Bench for poly_mul_param. Two instances (N=256, N=64) run
//                in lockstep from shared secret/public memories; results are
//                compared against a schoolbook negacyclic product model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_poly_mul_param;

    localparam int NA = 256;
    localparam int NB = 64;
    localparam logic [63:0] c_PAD_MASK = 64'hE000_E000_E000_E000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        res_ready;
    bit          stall_en;

    logic [3:0]  s_addr_a;
    logic [63:0] s_data_a;
    logic [7:0]  a_addr_a;
    logic [12:0] a_coeff_a;
    logic [63:0] res_data_a;
    logic        res_valid_a, busy_a, done_a;

    logic [1:0]  s_addr_b;
    logic [63:0] s_data_b;
    logic [5:0]  a_addr_b;
    logic [12:0] a_coeff_b;
    logic [63:0] res_data_b;
    logic        res_valid_b, busy_b, done_b;

    poly_mul_param #(.N(NA)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .s_addr(s_addr_a), .s_data(s_data_a),
        .a_addr(a_addr_a), .a_coeff(a_coeff_a),
        .res_data(res_data_a), .res_valid(res_valid_a), .res_ready(res_ready),
        .busy(busy_a), .done(done_a)
    );

    poly_mul_param #(.N(NB)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .s_addr(s_addr_b), .s_data(s_data_b),
        .a_addr(a_addr_b), .a_coeff(a_coeff_b),
        .res_data(res_data_b), .res_valid(res_valid_b), .res_ready(res_ready),
        .busy(busy_b), .done(done_b)
    );

    int s_mem [256];
    int a_mem [256];
    int exp_acc [2][256];
    int got [2][$];
    int dcnt [2];
    int done_cyc [2];
    bit hold_v [2];
    logic [63:0] hold_d [2];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int k, input int i);
        if (i < got[k].size()) return got[k][i];
        return -1;
    endfunction

    // ---------------- memory models (one-cycle read latency) ----------------
    always @(posedge clk) begin
        for (int c = 0; c < 16; c++) begin
            s_data_a[4*c +: 4] <= 4'(s_mem[int'(s_addr_a)*16 + c]);
            s_data_b[4*c +: 4] <= 4'(s_mem[int'(s_addr_b)*16 + c]);
        end
        a_coeff_a <= 13'(a_mem[a_addr_a]);
        a_coeff_b <= 13'(a_mem[a_addr_b]);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        res_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- result collection (sampled at negedge) ----------------
    task automatic sample(input int k, input logic v, input logic [63:0] d, input logic dn);
        if (v && hold_v[k]) chk($sformatf("hold%0d", k), d, hold_d[k]);
        if (v && res_ready) begin
            chk($sformatf("pad%0d", k), d & c_PAD_MASK, 64'd0);
            for (int l = 0; l < 4; l++) got[k].push_back(int'(d[16*l +: 13]));
        end
        hold_v[k] = v && !res_ready;
        hold_d[k] = d;
        if (dn) begin
            dcnt[k]++;
            done_cyc[k] = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sample(0, res_valid_a, res_data_a, done_a);
            sample(1, res_valid_b, res_data_b, done_b);
        end else begin
            hold_v[0] = 1'b0;
            hold_v[1] = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    // Schoolbook product in Z[x]/(x^n+1), then apply the mode to the
    // expected accumulators, all reduced mod 2^13.
    task automatic model_run(input logic [1:0] md);
        for (int k = 0; k < 2; k++) begin
            int n;
            int prod [256];
            n = (k == 0) ? NA : NB;
            for (int x = 0; x < 256; x++) prod[x] = 0;
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < n; j++) begin
                    if (i + j < n) prod[i + j]     += a_mem[i] * s_mem[j];
                    else           prod[i + j - n] -= a_mem[i] * s_mem[j];
                end
            end
            for (int x = 0; x < n; x++) begin
                int v;
                case (md)
                    2'b01:   v = exp_acc[k][x] + prod[x];
                    2'b10:   v = exp_acc[k][x] - prod[x];
                    default: v = prod[x];
                endcase
                exp_acc[k][x] = ((v % 8192) + 8192) % 8192;
            end
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) begin
            s_mem[i] = int'($urandom_range(0, 10)) - 5;
            a_mem[i] = int'($urandom_range(0, 8191));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy_a"},  64'(busy_a),      64'd0);
        chk({tag, "_done_a"},  64'(done_a),      64'd0);
        chk({tag, "_valid_a"}, 64'(res_valid_a), 64'd0);
        chk({tag, "_saddr_a"}, 64'(s_addr_a),    64'd0);
        chk({tag, "_aaddr_a"}, 64'(a_addr_a),    64'd0);
        chk({tag, "_data_a"},  res_data_a,       64'd0);
        chk({tag, "_busy_b"},  64'(busy_b),      64'd0);
        chk({tag, "_done_b"},  64'(done_b),      64'd0);
        chk({tag, "_valid_b"}, 64'(res_valid_b), 64'd0);
        chk({tag, "_saddr_b"}, 64'(s_addr_b),    64'd0);
        chk({tag, "_aaddr_b"}, 64'(a_addr_b),    64'd0);
        chk({tag, "_data_b"},  res_data_b,       64'd0);
    endtask

    // One full operation on both instances, then compare everything.
    task automatic run(input logic [1:0] md, input bit stall, input string tag);
        int base [2];
        int t0;
        model_run(md);
        stall_en = stall;
        for (int k = 0; k < 2; k++) begin
            got[k].delete();
            base[k] = dcnt[k];
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = md;
        @(posedge clk);
        #1;
        t0    = cyc;                   // the start cycle is t0-1
        start = 1'b0;
        mode  = 2'($urandom);          // must not affect the running operation
        for (int i = 0; i < 3000; i++) begin
            if (dcnt[0] > base[0] && dcnt[1] > base[1]) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        stall_en = 1'b0;
        chk({tag, "_donecnt_a"}, 64'(dcnt[0] - base[0]), 64'd1);
        chk({tag, "_donecnt_b"}, 64'(dcnt[1] - base[1]), 64'd1);
        if (!stall) begin
            // W_S + N + N/LANES + 3: 16+256+64+3 and 4+64+16+3
            chk({tag, "_lat_a"}, 64'(done_cyc[0] - (t0 - 1)), 64'd339);
            chk({tag, "_lat_b"}, 64'(done_cyc[1] - (t0 - 1)), 64'd87);
        end
        chk({tag, "_busy_a"}, 64'(busy_a), 64'd0);
        chk({tag, "_nres_a"}, 64'(got[0].size()), 64'(NA));
        chk({tag, "_nres_b"}, 64'(got[1].size()), 64'(NB));
        for (int i = 0; i < NA; i++)
            chk($sformatf("%s_a_c%0d", tag, i), 64'(qget(0, i)), 64'(exp_acc[0][i]));
        for (int i = 0; i < NB; i++)
            chk($sformatf("%s_b_c%0d", tag, i), 64'(qget(1, i)), 64'(exp_acc[1][i]));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base_d [2];
        rst       = 1'b0;
        start     = 1'b0;
        mode      = 2'b00;
        res_ready = 1'b1;
        stall_en  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            s_mem[i] = 0;
            a_mem[i] = 0;
            exp_acc[0][i] = 0;
            exp_acc[1][i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;

        // Identity secret: result equals the public polynomial.
        s_mem[0] = 1;
        for (int i = 0; i < 256; i++) a_mem[i] = i;
        run(2'b00, 1'b0, "ident");
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("ident_beat0_a%0d", l), 64'(qget(0, l)), 64'(l));
            chk($sformatf("ident_beat0_b%0d", l), 64'(qget(1, l)), 64'(l));
        end

        // x * x^255 = x^256 = -1
        for (int i = 0; i < 256; i++) begin
            s_mem[i] = 0;
            a_mem[i] = 0;
        end
        s_mem[1]   = 1;
        a_mem[255] = 1;
        run(2'b00, 1'b0, "wrap");
        chk("wrap_c0_a", 64'(qget(0, 0)), 64'd8191);

        // Constant polynomials: coefficient 0 is 10 - 255*10 = -2540 = 5652.
        for (int i = 0; i < 256; i++) begin
            s_mem[i] = 2;
            a_mem[i] = 5;
        end
        run(2'b00, 1'b0, "const_clr");
        chk("const_clr_c0_a", 64'(qget(0, 0)), 64'd5652);
        run(2'b01, 1'b0, "const_acc");
        chk("const_acc_c0_a", 64'(qget(0, 0)), 64'd3112);
        run(2'b10, 1'b0, "const_sub");
        chk("const_sub_c0_a", 64'(qget(0, 0)), 64'd5652);

        // Random data with a stalling consumer.
        fill_rand();
        run(2'b00, 1'b1, "stall");

        // Reset in the middle of MAC.
        fill_rand();
        base_d[0] = dcnt[0];
        base_d[1] = dcnt[1];
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_idle_outputs("abort");
        for (int i = 0; i < 256; i++) begin
            exp_acc[0][i] = 0;
            exp_acc[1][i] = 0;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (400) @(negedge clk);
        chk("abort_nodone_a", 64'(dcnt[0] - base_d[0]), 64'd0);
        chk("abort_nodone_b", 64'(dcnt[1] - base_d[1]), 64'd0);
        run(2'b01, 1'b0, "post_abort");

        // Random runs across all modes, including the alias code 2'b11.
        fill_rand();
        run(2'b11, 1'b0, "rnd_m3");
        fill_rand();
        run(2'b01, 1'b0, "rnd_acc");
        fill_rand();
        run(2'b10, 1'b1, "rnd_sub");
        fill_rand();
        run(2'b00, 1'b0, "rnd_clr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish (expected completion)");
        $fatal(1, "timeout");
    end

endmodule : tb_poly_mul_param
`default_nettype wire
